// File: rtl/dp_ram_ctrl.sv
// True dual-port RAM with collision arbitration, read-during-write mode select and a zero-fill sequencer.
// Define DP_RAM_OUT_REG_EN to add a second output register stage (read latency 2).
module dp_ram_ctrl #(
  parameter int DATA_W  = 4,
  parameter int ADDR_W  = 2,
  parameter int RD_MODE = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              enb,
  input  logic              wea,
  input  logic              web,
  input  logic [ADDR_W-1:0] addra,
  input  logic [ADDR_W-1:0] addrb,
  input  logic [DATA_W-1:0] dina,
  input  logic [DATA_W-1:0] dinb,
  input  logic              init_req,
  output logic [DATA_W-1:0] douta,
  output logic [DATA_W-1:0] doutb,
  output logic              valida,
  output logic              validb,
  output logic              collision,
  output logic              init_busy
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {INIT, RUN} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                init_busy_q, init_busy_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [DATA_W-1:0]   mem_d [DEPTH];
  logic [DATA_W-1:0]   douta1_q, douta1_d;
  logic [DATA_W-1:0]   doutb1_q, doutb1_d;
  logic                valida1_q, valida1_d;
  logic                validb1_q, validb1_d;
  logic                coll1_q, coll1_d;
  logic                same_addr;
  logic                coll;

  assign same_addr = (addra == addrb);
  assign coll      = ena && enb && same_addr && (wea || web);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    init_busy_d = init_busy_q;
    mem_d       = mem_q;
    douta1_d    = douta1_q;
    doutb1_d    = doutb1_q;
    valida1_d   = 1'b0;
    validb1_d   = 1'b0;
    coll1_d     = 1'b0;

    case (state_q)
      INIT: begin
        mem_d[cnt_q] = '0;
        if (cnt_q == ADDR_W'(DEPTH - 1)) begin
          state_d     = RUN;
          init_busy_d = 1'b0;
          cnt_d       = '0;
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end

      RUN: begin
        if (ena) begin
          valida1_d = 1'b1;
          douta1_d  = mem_q[addra];
          if (RD_MODE != 0) begin
            if (wea) douta1_d = dina;
            else if (coll && web) douta1_d = dinb;
          end
        end
        if (enb) begin
          validb1_d = 1'b1;
          doutb1_d  = mem_q[addrb];
          if (RD_MODE != 0) begin
            if (web) doutb1_d = dinb;
            else if (coll && wea) doutb1_d = dina;
          end
        end
        coll1_d = coll;

        // Port A owns the location when both ports write the same address
        if (ena && wea) mem_d[addra] = dina;
        if (enb && web && !(coll && wea)) mem_d[addrb] = dinb;

        if (init_req) begin
          state_d     = INIT;
          init_busy_d = 1'b1;
          cnt_d       = '0;
        end
      end

      default: begin
        state_d     = INIT;
        init_busy_d = 1'b1;
        cnt_d       = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= INIT;
      cnt_q       <= '0;
      init_busy_q <= 1'b1;
      douta1_q    <= '0;
      doutb1_q    <= '0;
      valida1_q   <= 1'b0;
      validb1_q   <= 1'b0;
      coll1_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_busy_q <= init_busy_d;
      douta1_q    <= douta1_d;
      doutb1_q    <= doutb1_d;
      valida1_q   <= valida1_d;
      validb1_q   <= validb1_d;
      coll1_q     <= coll1_d;
    end
  end

  // Storage is not reset; the fill sequencer defines its contents
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

`ifdef DP_RAM_OUT_REG_EN
  logic [DATA_W-1:0] douta2_q, douta2_d;
  logic [DATA_W-1:0] doutb2_q, doutb2_d;
  logic              valida2_q, valida2_d;
  logic              validb2_q, validb2_d;
  logic              coll2_q, coll2_d;

  always_comb begin
    douta2_d  = douta1_q;
    doutb2_d  = doutb1_q;
    valida2_d = valida1_q;
    validb2_d = validb1_q;
    coll2_d   = coll1_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      douta2_q  <= '0;
      doutb2_q  <= '0;
      valida2_q <= 1'b0;
      validb2_q <= 1'b0;
      coll2_q   <= 1'b0;
    end else begin
      douta2_q  <= douta2_d;
      doutb2_q  <= doutb2_d;
      valida2_q <= valida2_d;
      validb2_q <= validb2_d;
      coll2_q   <= coll2_d;
    end
  end

  assign douta     = douta2_q;
  assign doutb     = doutb2_q;
  assign valida    = valida2_q;
  assign validb    = validb2_q;
  assign collision = coll2_q;
`else
  assign douta     = douta1_q;
  assign doutb     = doutb1_q;
  assign valida    = valida1_q;
  assign validb    = validb1_q;
  assign collision = coll1_q;
`endif

  assign init_busy = init_busy_q;

endmodule

// File: doc/dp_ram_ctrl.md
# dp_ram_ctrl

Parametrised true dual-port RAM with per-port enables, selectable read-during-write mode, same-address collision arbitration and a hardware zero-fill sequencer. It is the successor to the fixed 4-entry × 4-bit dual-port RAM and sits behind two independent requesters, for example a producer and a consumer datapath, in the same clock domain. After reset, or on request, it sweeps every location to zero before accepting traffic.

## Interface
- DATA_W, 4, data width per word
- ADDR_W, 2, address width; DEPTH = 2**ADDR_W
- RD_MODE, 0, read-during-write on the same port: 0 returns old data (read-first), 1 returns new data (write-first)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- ena, enb  in  1  port enable; access occurs only when high
- wea, web  in  1  write select; with en high, 1 = write, 0 = read
- addra, addrb  in  ADDR_W  port address
- dina, dinb  in  DATA_W  write data
- init_req  in  1  single-cycle pulse that restarts the zero-fill; honoured only in RUN
- douta, doutb  out  DATA_W  read data, registered
- valida, validb  out  1  pulses high with the corresponding dout
- collision  out  1  pulses high when both ports hit the same address and at least one is writing
- init_busy  out  1  high while the zero-fill is in progress

## Operation
- FSM states: INIT and RUN.
  - Reset enters INIT with fill counter = 0.
  - INIT writes 0 to location counter each cycle for DEPTH cycles, then moves to RUN.
  - RUN moves to INIT on init_req.
- In INIT, all port enables are ignored: no memory writes from ports, valid low, collision low.
- Each enabled access (read or write) produces registered dout plus a valid pulse.
- On a write, dout is the old contents when RD_MODE=0 and dina/dinb when RD_MODE=1.
- When a port is not enabled, dout holds its last value and valid is 0.
- Collision rules, when both ports are enabled and addra == addrb:
  - Both writing: dina is stored, dinb is discarded, collision=1.
  - One writing, one reading: the write completes. The reader gets old data if RD_MODE=0, or the written data if RD_MODE=1. collision=1.
  - Both reading: no collision; both ports return the same data.
- The collision pulse is aligned with valida/validb.

## Timing
- Reset values:
  - douta = doutb = 0
  - valida = validb = 0
  - collision = 0
  - init_busy = 1
  - state = INIT
- Zero-fill takes exactly DEPTH cycles after rst_n deasserts. init_busy falls on the cycle RUN is entered, and the first port access is accepted on that cycle.
- init_req in RUN: init_busy rises the next cycle, and the fill again takes DEPTH cycles. A port access presented in the same cycle as init_req is still performed. init_req during INIT is ignored (no restart).
- Read latency: 1 cycle. An access at edge N gives dout/valid after edge N; valid is 1 for that single cycle.
- Write is visible to a read issued on the following cycle on either port.
- Reset asserted mid-fill or mid-access: outputs go to reset values immediately and the fill restarts from 0. Memory contents are undefined until the fill completes.
- Address wrap: none. The full ADDR_W range is valid, and the fill counter terminates at DEPTH-1.

## Configuration
- DP_RAM_OUT_REG_EN defined: a second output register stage is added. douta/doutb, valida/validb and collision are all delayed to latency 2. Reset values are unchanged, and valid stays aligned with data.
- DP_RAM_OUT_REG_EN undefined: latency 1 as above.

## Test plan
- Fill check (DATA_W=4, ADDR_W=2): release reset → init_busy high for exactly 4 cycles. Then read all addresses → dout=0, each with a valid pulse.
- Write/read: A writes 0xA to address 1; next cycle B reads address 1 → doutb=0xA one cycle later, validb=1, collision=0.
- Write-write collision: A writes 0x5 and B writes 0x9 to address 2 in the same cycle → collision=1; a later read of address 2 returns 0x5.
- Read-during-write on one cycle, address 3 preloaded 0x1; A writes 0x7 to address 3 while B reads address 3 → collision=1. doutb=0x1 with RD_MODE=0, doutb=0x7 with RD_MODE=1. douta follows the same rule.
- Re-init: write 0xF everywhere, then pulse init_req → init_busy high for 4 cycles, port enables ignored, all reads return 0 afterwards.
- Latency with DP_RAM_OUT_REG_EN: read issued at edge N → valid and data after edge N+1. Assert rst_n low mid-fill → outputs reset and the fill restarts at 4 cycles.
